// File: rtl/cycle_seq_if.sv
// cycle_seq_if: T-step/M-cycle sequencer handshake bundle.
// CYCLE_SEQ_OVERFLOW_CHECK_EN adds the sticky o_Cycle_Overflow flag.
interface cycle_seq_if;
    logic       i_Clock_Enable;
    logic       i_IR_Fetch;
    logic       i_Wait;
    logic       i_Halt_Req;
    logic       i_Wake;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic       o_M_Cycle_End;
    logic       o_Halted;
`ifdef CYCLE_SEQ_OVERFLOW_CHECK_EN
    logic       o_Cycle_Overflow;
`endif
    modport master (
`ifdef CYCLE_SEQ_OVERFLOW_CHECK_EN
        input  o_Cycle_Overflow,
`endif
        output i_Clock_Enable, i_IR_Fetch, i_Wait, i_Halt_Req, i_Wake,
        input  o_Cycle_Step, o_Cycle_Count, o_M_Cycle_End, o_Halted
    );
    modport slave (
`ifdef CYCLE_SEQ_OVERFLOW_CHECK_EN
        output o_Cycle_Overflow,
`endif
        input  i_Clock_Enable, i_IR_Fetch, i_Wait, i_Halt_Req, i_Wake,
        output o_Cycle_Step, o_Cycle_Count, o_M_Cycle_End, o_Halted
    );
endinterface

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: one-hot T-step / M-cycle sequencer with wait stalls and HALT.
// CYCLE_SEQ_OVERFLOW_CHECK_EN adds a sticky count-overflow flag.
module cycle_sequencer (
    input logic        i_Clk,
    input logic        i_Reset,
    cycle_seq_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] count_q, count_d;
    logic       m_end;
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        m_end   = bus.i_Clock_Enable & step_q[3] & ~bus.i_Wait & (state_q == RUN) & ~i_Reset;
        if (state_q == HALTED) begin
            step_d  = 4'b0001;
            count_d = 8'h01;
            state_d = (bus.i_Clock_Enable && bus.i_Wake) ? RUN : HALTED;
        end else if (m_end) begin
            step_d  = 4'b0001;
            // count saturates at the last slot rather than wrapping to zero
            count_d = (bus.i_Halt_Req || bus.i_IR_Fetch) ? 8'h01 :
                      count_q[7] ? 8'h80 : {count_q[6:0], 1'b0};
            state_d = bus.i_Halt_Req ? HALTED : RUN;
        end else if (bus.i_Clock_Enable && !step_q[3]) begin
            step_d = {step_q[2:0], 1'b0};
        end
    end
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= RUN;
            step_q  <= 4'b0001;
            count_q <= 8'h01;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end
    assign bus.o_Cycle_Step  = step_q;
    assign bus.o_Cycle_Count = count_q;
    assign bus.o_M_Cycle_End = m_end;
    assign bus.o_Halted      = (state_q == HALTED);
`ifdef CYCLE_SEQ_OVERFLOW_CHECK_EN
    logic ovf_q;
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            ovf_q <= 1'b0;
        else if (m_end && !bus.i_Halt_Req && !bus.i_IR_Fetch && count_q[7])
            ovf_q <= 1'b1;
    end
    assign bus.o_Cycle_Overflow = ovf_q;
`endif
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: i_Clk and i_Reset.
REQ-002 i_Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  asynchronous active-high reset.
REQ-004 i_Clock_Enable  input  1  T-cycle advance qualifier; no state change when low (reset excepted).
REQ-005 i_IR_Fetch  input  1  from the active microcode: the current M-cycle is the opcode fetch of the next instruction.
REQ-006 i_Wait  input  1  memory stall request, sampled at step 3.
REQ-007 i_Halt_Req  input  1  HALT executed, sampled at M-cycle end.
REQ-008 i_Wake  input  1  interrupt pending; releases HALT.
REQ-009 o_Cycle_Step  output  4  one-hot T-step within the current M-cycle, bit0 = first.
REQ-010 o_Cycle_Count  output  8  one-hot M-cycle index within the instruction, bit0 = first.
REQ-011 o_M_Cycle_End  output  1  combinational pulse: the current CE edge closes the M-cycle.
REQ-012 o_Halted  output  1  high while in HALTED state.

Function
REQ-013 States SHALL be RUN and HALTED, encoded internally.
REQ-014 In RUN, on CE with o_Cycle_Step not bit3, o_Cycle_Step SHALL rotate left by one (0001->0010->0100->1000).
REQ-015 o_M_Cycle_End SHALL equal i_Clock_Enable & o_Cycle_Step[3] & !i_Wait & RUN.
REQ-016 On CE at step 3 with i_Wait high, step and count SHALL hold; stall length unbounded.
REQ-017 On M-cycle end, o_Cycle_Step SHALL return to 0001.
REQ-018 On M-cycle end, next count priority: i_Halt_Req -> HALTED, count 0x01; else i_IR_Fetch -> count 0x01; else count shifts left one.
REQ-019 When count is 0x80 and shifts without i_IR_Fetch, count SHALL saturate at 0x80 (never zero, never wrap).
REQ-020 In HALTED, step SHALL stay 0001, count 0x01, o_M_Cycle_End 0, o_Halted 1.
REQ-021 In HALTED, on CE with i_Wake high, the block SHALL enter RUN the following cycle with step 0001, count 0x01.
REQ-022 i_Wake in RUN and i_Halt_Req while HALTED SHALL be ignored.
REQ-023 i_Wait and i_Halt_Req together at step 3 SHALL stall; halt is taken only when the M-cycle actually ends.
REQ-024 Outputs o_Cycle_Step and o_Cycle_Count SHALL be registered and always exactly one-hot.

Reset
REQ-025 On i_Reset asserted, immediately and independent of i_Clk: state RUN, o_Cycle_Step 0001, o_Cycle_Count 0x01, o_Halted 0.
REQ-026 Reset mid-stall or mid-HALT SHALL abandon that condition; the first CE after deassertion advances step to 0010.
REQ-027 o_M_Cycle_End SHALL be 0 while i_Reset is high.

Configuration
REQ-028 Macro CYCLE_SEQ_OVERFLOW_CHECK_EN: when defined, adds output o_Cycle_Overflow (1 bit), a sticky flag set when a shift is attempted at count 0x80 without i_IR_Fetch, cleared only by reset.
REQ-029 Without CYCLE_SEQ_OVERFLOW_CHECK_EN, the port and flag logic SHALL be absent; saturation behaviour of REQ-019 is unchanged.

Verification
REQ-030 Reset, CE held high 12 cycles, i_IR_Fetch low -> step sequence 0001,0010,0100,1000 repeating; count 0x01,0x02,0x04.
REQ-031 Five M-cycles with i_IR_Fetch high only during the fifth -> count 0x01..0x10, then 0x01 at the next M-cycle.
REQ-032 i_Wait high 3 cycles at step 1000 -> step holds 1000 three cycles, o_M_Cycle_End low, then 0001 with count shifted.
REQ-033 i_Halt_Req at M-cycle end, i_Wake after 10 cycles -> o_Halted 1 for that span, step 0001/count 0x01, RUN resumes next cycle.
REQ-034 Nine M-cycles without i_IR_Fetch (macro defined) -> count saturates 0x80, o_Cycle_Overflow 1 and held until reset.
REQ-035 i_Reset pulsed asynchronously during a stall at count 0x08 -> outputs 0001/0x01/halted 0 before the next clock edge.
